// File: rtl/usb_dbg_ctrl_engine_pkg.sv
// ----------------------------------------------------------------------------
// usb_dbg_ctrl_engine_pkg
//   Shared definitions for the USB debug-class control-request engine:
//   request-type and request codes, error codes, the engine state encoding
//   and a packed view of the 8-byte SETUP packet.
//   No ports (package).
// ----------------------------------------------------------------------------
package usb_dbg_ctrl_engine_pkg;

    // bmRequestType values accepted by the engine
    localparam logic [7:0] RT_SET_CLASS = 8'h21;
    localparam logic [7:0] RT_GET_CLASS = 8'hA1;

    // bRequest codes
    localparam logic [7:0] REQ_SET_OP_MODE = 8'h05;
    localparam logic [7:0] REQ_SET_TRACE   = 8'h06;
    localparam logic [7:0] REQ_SET_RESET   = 8'h0A;
    localparam logic [7:0] REQ_GET_OP_MODE = 8'h85;
    localparam logic [7:0] REQ_GET_TRACE   = 8'h86;
    localparam logic [7:0] REQ_GET_INFO    = 8'h87;
    localparam logic [7:0] REQ_GET_ERROR   = 8'h88;

    // Error register codes
    localparam logic [7:0] ERR_NONE            = 8'h00;
    localparam logic [7:0] ERR_OUT_OF_RANGE    = 8'h05;
    localparam logic [7:0] ERR_INVALID_VALUE   = 8'h06;
    localparam logic [7:0] ERR_INVALID_UNIT    = 8'h07;
    localparam logic [7:0] ERR_INVALID_REQUEST = 8'h09;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_DATA_OUT,
        S_DATA_IN,
        S_STATUS,
        S_STALL
    } state_e;

    // Field layout of setup_pkt: first member lands in the MSBs, so this
    // matches [63:56] bmRequestType ... [15:0] wLength directly.
    typedef struct packed {
        logic [7:0]  bm_request_type;
        logic [7:0]  b_request;
        logic [15:0] w_value;
        logic [15:0] w_index;
        logic [15:0] w_length;
    } setup_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/usb_dbg_ctrl_engine_if.sv
// ----------------------------------------------------------------------------
// usb_dbg_ctrl_engine_if
//   Endpoint-0 side of the debug control engine: SETUP strobe, OUT/IN
//   data-stage byte handshakes and request status.
//   Signals:
//     setup_valid / setup_pkt[63:0]   decoded SETUP packet strobe
//     rx_data / rx_valid / rx_ready   OUT data-stage byte (host -> engine)
//     tx_data / tx_valid / tx_ready   IN data-stage byte (engine -> host)
//     status_ack / status_stall       one-cycle completion pulses
//     busy                            engine not idle
//   Modports: master = host/endpoint side, slave = engine.
// ----------------------------------------------------------------------------
interface usb_dbg_ctrl_engine_if;
    logic        setup_valid;
    logic [63:0] setup_pkt;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        status_ack;
    logic        status_stall;
    logic        busy;

    modport master (
        output setup_valid, setup_pkt, rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid, status_ack, status_stall, busy
    );

    modport slave (
        input  setup_valid, setup_pkt, rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid, status_ack, status_stall, busy
    );
endinterface

// File: rtl/usb_dbg_ctrl_engine_byte_serdes.sv
// ----------------------------------------------------------------------------
// usb_dbg_ctrl_engine_byte_serdes
//   Byte-wide LSB-first staging buffer plus byte counter shared by both data
//   stages. OUT bytes enter at byte CFG_BYTES-1 and shift down, so after
//   CFG_BYTES bytes the first one received sits in byte 0. IN bytes leave
//   from byte 0 and the buffer shifts down behind them.
//   Ports:
//     clk, rst             clock, async active-high reset
//     load                 load snapshot, clear counter, set target length
//     load_data, load_len  snapshot (BUF_BYTES bytes) and byte count target
//     shift_in, rx_byte    accept one OUT byte
//     shift_out            one IN byte was taken
//     cfg_data             low CFG_BYTES bytes of the buffer (commit source)
//     tx_byte              byte currently presented for IN
//     last                 the next transferred byte completes the stage
// ----------------------------------------------------------------------------
module usb_dbg_ctrl_engine_byte_serdes #(
    parameter int CFG_BYTES = 8,
    parameter int BUF_BYTES = 8,
    parameter int CW        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [8*BUF_BYTES-1:0] load_data,
    input  logic [CW-1:0]          load_len,
    input  logic                   shift_in,
    input  logic [7:0]             rx_byte,
    input  logic                   shift_out,
    output logic [8*CFG_BYTES-1:0] cfg_data,
    output logic [7:0]             tx_byte,
    output logic                   last
);

    logic [8*BUF_BYTES-1:0] buf_q;
    logic [8*BUF_BYTES-1:0] in_next;
    logic [8*BUF_BYTES-1:0] out_next;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          len_q;

    // OUT shift only moves the CFG_BYTES region; bytes above it hold.
    for (genvar i = 0; i < BUF_BYTES; i++) begin : g_in_byte
        if (i == CFG_BYTES - 1) begin : g_entry
            assign in_next[8*i +: 8] = rx_byte;
        end else if (i < CFG_BYTES - 1) begin : g_shift
            assign in_next[8*i +: 8] = buf_q[8*(i+1) +: 8];
        end else begin : g_hold
            assign in_next[8*i +: 8] = buf_q[8*i +: 8];
        end
    end

    assign out_next = {8'h00, buf_q[8*BUF_BYTES-1:8]};

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else if (load) begin
            buf_q <= load_data;
            cnt_q <= '0;
            len_q <= load_len;
        end else if (shift_in) begin
            buf_q <= in_next;
            cnt_q <= cnt_q + CW'(1);
        end else if (shift_out) begin
            buf_q <= out_next;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign cfg_data = buf_q[8*CFG_BYTES-1:0];
    assign tx_byte  = buf_q[7:0];
    assign last     = ((cnt_q + CW'(1)) == len_q);

endmodule

// File: rtl/usb_dbg_ctrl_engine.sv
// ----------------------------------------------------------------------------
// usb_dbg_ctrl_engine
//   USB debug-class control-request engine for endpoint 0. Decodes a SETUP
//   packet, validates type/request/interface/unit, runs the byte-wide data
//   stage, commits per-unit registers and closes each request with a single
//   ACK or STALL pulse.
//   Ports:
//     clk, rst     clock, async active-high reset
//     bus          endpoint-0 handshake interface (slave side)
//     op_mode      per-unit operating mode, unit u at [8u+7:8u]
//     trace_cfg    per-unit trace config, unit u at [8*CFG_BYTES*u +: 8*CFG_BYTES]
//     unit_reset   one-cycle pulse for the unit addressed by SET_RESET
// ----------------------------------------------------------------------------
module usb_dbg_ctrl_engine
    import usb_dbg_ctrl_engine_pkg::*;
#(
    parameter int          NUM_UNITS = 4,
    parameter int          CFG_BYTES = 8,
    parameter logic [7:0]  IF_NUM    = 8'h00,
    parameter logic [7:0]  MAX_MODE  = 8'h03,
    parameter logic [31:0] CAPS      = 32'h0000_0580
) (
    input  logic                             clk,
    input  logic                             rst,
    usb_dbg_ctrl_engine_if.slave             bus,
    output logic [8*NUM_UNITS-1:0]           op_mode,
    output logic [8*CFG_BYTES*NUM_UNITS-1:0] trace_cfg,
    output logic [NUM_UNITS-1:0]             unit_reset
);

    localparam int          BUF_BYTES  = max_int(CFG_BYTES, 4);
    localparam int          CW         = $clog2(BUF_BYTES + 1);
    localparam int          UW         = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int          TW         = 8 * CFG_BYTES;
    localparam logic [8:0]  UNIT_LIMIT = 9'(NUM_UNITS);
    localparam logic [15:0] CFG_LEN    = 16'(CFG_BYTES);
    localparam logic [15:0] INFO_LEN   = 16'd4;

    state_e state_q, state_d;
    setup_t setup_q;
    logic [7:0] err_q;
    logic [7:0] code_q;
    logic [NUM_UNITS-1:0][7:0]    op_mode_q;
    logic [NUM_UNITS-1:0][TW-1:0] trace_q;

    logic [7:0]    unit_id;
    logic [UW-1:0] unit_idx;
    logic [7:0]    mode;

    // Decode results, meaningful while state_q == S_DECODE
    logic [7:0]             dec_err;
    state_e                 dec_next;
    logic [CW-1:0]          dec_len;
    logic [8*BUF_BYTES-1:0] dec_snap;

    logic rx_fire, tx_fire, last;
    logic commit, stall_fire;
    logic [TW-1:0] cfg_data;
    logic [7:0]    tx_byte;
    logic          unused_bits;

    assign unit_id     = setup_q.w_index[15:8];
    assign unit_idx    = unit_id[UW-1:0];
    assign mode        = setup_q.w_value[7:0];
    assign unused_bits = ^{setup_q.w_value[15:8], unit_id};

    // ------------------------------------------------------------------
    // Request decode: first failing check sets the error code.
    // ------------------------------------------------------------------
    always_comb begin
        logic          type_ok;
        logic          req_ok;
        logic          needs_unit;
        logic [15:0]   nat_len;
        logic [15:0]   xfer;
        // NOTE: every variable gets a default before any branch; a path that
        // skips an assignment would otherwise infer a latch.
        type_ok    = 1'b0;
        req_ok     = 1'b0;
        needs_unit = 1'b1;
        nat_len    = 16'd0;
        xfer       = 16'd0;
        dec_err    = ERR_NONE;
        dec_next   = S_STATUS;
        dec_len    = '0;
        dec_snap   = '0;

        if (setup_q.bm_request_type == RT_SET_CLASS) begin
            type_ok = 1'b1;
            case (setup_q.b_request)
                REQ_SET_OP_MODE, REQ_SET_TRACE, REQ_SET_RESET: req_ok = 1'b1;
                default: req_ok = 1'b0;
            endcase
        end else if (setup_q.bm_request_type == RT_GET_CLASS) begin
            type_ok = 1'b1;
            case (setup_q.b_request)
                REQ_GET_OP_MODE, REQ_GET_TRACE: req_ok = 1'b1;
                REQ_GET_INFO, REQ_GET_ERROR: begin
                    req_ok     = 1'b1;
                    needs_unit = 1'b0;
                end
                default: req_ok = 1'b0;
            endcase
        end

        if (!type_ok || !req_ok) begin
            dec_err = ERR_INVALID_REQUEST;
        end else if (setup_q.w_index[7:0] != IF_NUM ||
                     (needs_unit && ({1'b0, unit_id} >= UNIT_LIMIT))) begin
            dec_err = ERR_INVALID_UNIT;
        end else begin
            case (setup_q.b_request)
                REQ_SET_OP_MODE: begin
                    if (setup_q.w_length != 16'd0) dec_err = ERR_INVALID_VALUE;
                    else if (mode > MAX_MODE)      dec_err = ERR_OUT_OF_RANGE;
                end
                REQ_SET_TRACE: begin
                    if (setup_q.w_length != CFG_LEN) begin
                        dec_err = ERR_INVALID_VALUE;
                    end else begin
                        dec_next = S_DATA_OUT;
                        dec_len  = CW'(CFG_BYTES);
                    end
                end
                REQ_SET_RESET: begin
                    if (setup_q.w_length != 16'd0) dec_err = ERR_INVALID_VALUE;
                end
                REQ_GET_OP_MODE: begin
                    nat_len       = 16'd1;
                    dec_snap[7:0] = op_mode_q[unit_idx];
                end
                REQ_GET_TRACE: begin
                    nat_len           = CFG_LEN;
                    dec_snap[TW-1:0]  = trace_q[unit_idx];
                end
                REQ_GET_INFO: begin
                    nat_len        = INFO_LEN;
                    dec_snap[31:0] = CAPS;
                end
                default: begin  // GET_ERROR: only legal request left
                    nat_len       = 16'd1;
                    dec_snap[7:0] = err_q;
                end
            endcase

            if (setup_q.bm_request_type == RT_GET_CLASS) begin
                xfer    = (setup_q.w_length < nat_len) ? setup_q.w_length : nat_len;
                dec_len = CW'(xfer);
                if (xfer != 16'd0) dec_next = S_DATA_IN;
            end
        end

        if (dec_err != ERR_NONE) dec_next = S_STALL;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    assign rx_fire = (state_q == S_DATA_OUT) && bus.rx_valid;
    assign tx_fire = (state_q == S_DATA_IN) && bus.tx_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_IDLE;
            S_DECODE:   state_d = dec_next;
            S_DATA_OUT: if (rx_fire && last) state_d = S_STATUS;
            S_DATA_IN:  if (tx_fire && last) state_d = S_STATUS;
            S_STATUS:   state_d = S_IDLE;
            S_STALL:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        // A new SETUP always wins: the current request is dropped silently.
        if (bus.setup_valid) state_d = S_DECODE;
    end

    // Completion only counts if it is not being pre-empted by a new SETUP.
    assign commit     = (state_q == S_STATUS) && !bus.setup_valid;
    assign stall_fire = (state_q == S_STALL) && !bus.setup_valid;

    assign bus.rx_ready     = (state_q == S_DATA_OUT);
    assign bus.tx_valid     = (state_q == S_DATA_IN);
    assign bus.tx_data      = tx_byte;
    assign bus.status_ack   = commit;
    assign bus.status_stall = stall_fire;
    assign bus.busy         = (state_q != S_IDLE);

    always_comb begin
        unit_reset = '0;
        if (commit && setup_q.b_request == REQ_SET_RESET) unit_reset[unit_idx] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Data-stage staging buffer
    // ------------------------------------------------------------------
    usb_dbg_ctrl_engine_byte_serdes #(
        .CFG_BYTES (CFG_BYTES),
        .BUF_BYTES (BUF_BYTES),
        .CW        (CW)
    ) u_serdes (
        .clk       (clk),
        .rst       (rst),
        .load      (state_q == S_DECODE),
        .load_data (dec_snap),
        .load_len  (dec_len),
        .shift_in  (rx_fire),
        .rx_byte   (bus.rx_data),
        .shift_out (tx_fire),
        .cfg_data  (cfg_data),
        .tx_byte   (tx_byte),
        .last      (last)
    );

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    // NOTE: the per-unit config arrays are architectural state with defined
    // reset values, so they sit on the async reset like any other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            setup_q   <= '0;
            code_q    <= ERR_NONE;
            err_q     <= ERR_NONE;
            op_mode_q <= '0;
            trace_q   <= '0;
        end else begin
            if (bus.setup_valid)       setup_q <= bus.setup_pkt;
            if (state_q == S_DECODE)   code_q  <= dec_err;
            if (commit) begin
                case (setup_q.b_request)
                    REQ_SET_OP_MODE: op_mode_q[unit_idx] <= mode;
                    REQ_SET_TRACE:   trace_q[unit_idx]   <= cfg_data;
                    default: ;
                endcase
                if (setup_q.b_request != REQ_GET_ERROR) err_q <= ERR_NONE;
            end
            if (stall_fire) err_q <= code_q;
        end
    end

    assign op_mode   = op_mode_q;
    assign trace_cfg = trace_q;

endmodule

// File: tb/tb_usb_dbg_ctrl_engine.sv
// ----------------------------------------------------------------------------
// tb_usb_dbg_ctrl_engine
//   Directed scoreboard bench for usb_dbg_ctrl_engine (default parameters).
//   Stimulus pushes expected TX bytes / ACK / STALL events into a queue; an
//   independent monitor on the falling edge pops and compares each event the
//   DUT presents. Register outputs are checked directly after each request.
// ----------------------------------------------------------------------------
module tb_usb_dbg_ctrl_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;

    usb_dbg_ctrl_engine_if bus_if();

    logic [31:0]  op_mode;
    logic [255:0] trace_cfg;
    logic [3:0]   unit_reset;

    usb_dbg_ctrl_engine dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .op_mode    (op_mode),
        .trace_cfg  (trace_cfg),
        .unit_reset (unit_reset)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_TX, EV_ACK, EV_STALL} ev_kind_e;
    typedef struct packed {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    ev_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic exp_tx(input logic [7:0] b);
        sb_q.push_back('{kind: EV_TX, data: b});
    endtask

    task automatic exp_ack(input logic [3:0] ur);
        sb_q.push_back('{kind: EV_ACK, data: {4'b0, ur}});
    endtask

    task automatic exp_stall();
        sb_q.push_back('{kind: EV_STALL, data: 8'h00});
    endtask

    task automatic observe(input ev_kind_e k, input logic [7:0] d);
        ev_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %h, expected no event", k, d);
        end else begin
            e = sb_q.pop_front();
            check("event_kind", 64'(k), 64'(e.kind));
            check("event_data", 64'(d), 64'(e.data));
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, mid-cycle.
    // ------------------------------------------------------------------
    logic       hold_q = 1'b0;
    logic [7:0] hold_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            hold_q <= 1'b0;
        end else begin
            if (hold_q && bus_if.tx_valid) check("tx_stable", 64'(bus_if.tx_data), 64'(hold_data));
            hold_q    <= bus_if.tx_valid && !bus_if.tx_ready;
            hold_data <= bus_if.tx_data;
            if (bus_if.tx_valid && bus_if.tx_ready) observe(EV_TX, bus_if.tx_data);
            if (bus_if.status_ack)   observe(EV_ACK, {4'b0, unit_reset});
            if (bus_if.status_stall) observe(EV_STALL, {4'b0, unit_reset});
            if (bus_if.status_ack || bus_if.status_stall)
                check("ack_stall_exclusive", 64'(bus_if.status_ack & bus_if.status_stall), 64'd0);
        end
    end

    // ------------------------------------------------------------------
    // Drivers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_setup(input logic [63:0] p);
        bus_if.setup_pkt   = p;
        bus_if.setup_valid = 1'b1;
        tick();
        bus_if.setup_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input int gap);
        bit acc = 1'b0;
        int guard = 0;
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = bus_if.rx_ready;
            tick();
            guard++;
        end
        bus_if.rx_valid = 1'b0;
        if (!acc) check("rx_accept_timeout", 64'(acc), 64'd1);
        repeat (gap) tick();
    endtask

    task automatic run_until_idle(input bit toggle);
        bit idle = 1'b0;
        int guard = 0;
        while (!idle && guard < 200) begin
            @(negedge clk);
            idle = !bus_if.busy;
            if (!idle) begin
                tick();
                if (toggle) bus_if.tx_ready = ~bus_if.tx_ready;
            end
            guard++;
        end
        if (!idle) check("idle_timeout", 64'(bus_if.busy), 64'd0);
        tick();
        bus_if.tx_ready = 1'b1;
    endtask

    task automatic request(input logic [63:0] p, input bit toggle);
        send_setup(p);
        run_until_idle(toggle);
    endtask

    task automatic get_error(input logic [7:0] code);
        exp_tx(code);
        exp_ack(4'b0000);
        request(64'hA1_88_0000_0000_0001, 1'b0);
    endtask

    initial begin
        bus_if.setup_valid = 1'b0;
        bus_if.setup_pkt   = '0;
        bus_if.rx_data     = 8'h00;
        bus_if.rx_valid    = 1'b0;
        bus_if.tx_ready    = 1'b1;

        // Reset state
        #2;
        check("rst_busy",       64'(bus_if.busy), 64'd0);
        check("rst_tx_valid",   64'(bus_if.tx_valid), 64'd0);
        check("rst_rx_ready",   64'(bus_if.rx_ready), 64'd0);
        check("rst_ack_stall",  64'({bus_if.status_ack, bus_if.status_stall}), 64'd0);
        check("rst_op_mode",    64'(op_mode), 64'd0);
        check("rst_trace_or",   64'(|trace_cfg), 64'd0);
        check("rst_unit_reset", 64'(unit_reset), 64'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1. SET_OPERATING_MODE unit 1 mode 2
        exp_ack(4'b0000);
        request(64'h21_05_0002_0100_0000, 1'b0);
        check("t1_op_mode", 64'(op_mode), 64'h0000_0200);

        // 2. SET_TRACE unit 3, bytes 01..08 with gaps
        exp_ack(4'b0000);
        send_setup(64'h21_06_0000_0300_0008);
        for (int i = 1; i <= 8; i++) send_rx(8'(i), i % 2);
        run_until_idle(1'b0);
        check("t2_trace3", trace_cfg[3*64 +: 64], 64'h0807060504030201);
        check("t2_trace0to2_or", 64'(|trace_cfg[191:0]), 64'd0);

        // SET_TRACE with wrong length
        exp_stall();
        request(64'h21_06_0000_0300_0007, 1'b0);
        get_error(8'h06);

        // 3. GET_TRACE unit 3, 4 bytes, tx_ready toggling
        exp_tx(8'h01); exp_tx(8'h02); exp_tx(8'h03); exp_tx(8'h04);
        exp_ack(4'b0000);
        bus_if.tx_ready = 1'b0;
        request(64'hA1_86_0000_0300_0004, 1'b1);

        // 4. Mode out of range, GET_ERROR twice keeps the code
        exp_stall();
        request(64'h21_05_0007_0000_0000, 1'b0);
        check("t4_op_mode_kept", 64'(op_mode), 64'h0000_0200);
        get_error(8'h05);
        get_error(8'h05);

        // 5. Bad unit / bad request / bad interface / bad type
        exp_stall();
        request(64'h21_05_0001_0900_0000, 1'b0);
        get_error(8'h07);
        exp_stall();
        request(64'h21_42_0000_0000_0000, 1'b0);
        get_error(8'h09);
        exp_stall();
        request(64'hA1_85_0000_0400_0001, 1'b0);   // unit == NUM_UNITS
        get_error(8'h07);
        exp_stall();
        request(64'hA1_87_0000_0001_0004, 1'b0);   // interface 1
        get_error(8'h07);
        exp_stall();
        request(64'hC0_05_0001_0000_0000, 1'b0);
        get_error(8'h09);
        check("t5_op_mode_kept", 64'(op_mode), 64'h0000_0200);
        check("t5_trace3_kept", trace_cfg[3*64 +: 64], 64'h0807060504030201);

        // GET_INFO ignores unit, truncated by wLength, then clears error
        exp_tx(8'h80); exp_tx(8'h05);
        exp_ack(4'b0000);
        request(64'hA1_87_0000_0900_0002, 1'b0);
        get_error(8'h00);
        exp_tx(8'h80); exp_tx(8'h05); exp_tx(8'h00); exp_tx(8'h00);
        exp_ack(4'b0000);
        request(64'hA1_87_0000_0000_0010, 1'b0);
        // GET with wLength 0 goes straight to status
        exp_ack(4'b0000);
        request(64'hA1_85_0000_0100_0000, 1'b0);
        exp_tx(8'h02);
        exp_ack(4'b0000);
        request(64'hA1_85_0000_0100_0001, 1'b0);

        // SET_RESET unit 2
        exp_ack(4'b0100);
        request(64'h21_0A_0000_0200_0000, 1'b0);

        // 6. Abort SET_TRACE after 3 bytes, then a full one
        send_setup(64'h21_06_0000_0200_0008);
        send_rx(8'hAA, 0); send_rx(8'hBB, 0); send_rx(8'hCC, 0);
        exp_ack(4'b0000);
        send_setup(64'h21_06_0000_0200_0008);
        check("t6_trace2_after_abort", trace_cfg[2*64 +: 64], 64'd0);
        for (int i = 0; i < 8; i++) send_rx(8'h11 + 8'(i), 0);
        run_until_idle(1'b0);
        check("t6_trace2", trace_cfg[2*64 +: 64], 64'h1817161514131211);
        check("t6_trace3_kept", trace_cfg[3*64 +: 64], 64'h0807060504030201);

        // Reset in the middle of GET_TRACE
        bus_if.tx_ready = 1'b0;
        send_setup(64'hA1_86_0000_0300_0008);
        repeat (3) tick();
        check("t6_get_active", 64'(bus_if.tx_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_tx_valid", 64'(bus_if.tx_valid), 64'd0);
        check("t6_rst_busy",     64'(bus_if.busy), 64'd0);
        check("t6_rst_op_mode",  64'(op_mode), 64'd0);
        check("t6_rst_trace_or", 64'(|trace_cfg), 64'd0);
        tick();
        rst = 1'b0;
        bus_if.tx_ready = 1'b1;
        tick();

        exp_tx(8'h00);
        exp_ack(4'b0000);
        request(64'hA1_85_0000_0100_0001, 1'b0);
        get_error(8'h00);

        repeat (3) tick();
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
